// File: rtl/conv_acc_queue_if.sv
// Bundles the store, accumulate and drain handshakes of the accumulating write queue.
// slave = queue side, master = convolution engine / write-port side.
interface conv_acc_queue_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 17,
    parameter int LANES  = 2,
    parameter int LANE_W = 16
);
    localparam int DATA_W = LANES * LANE_W;
    localparam int WEB_W  = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [WEB_W-1:0]  s_web;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic [WEB_W-1:0]  a_web;
    logic              a_hit;
    logic              a_drop;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [WEB_W-1:0]  m_web;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport slave (
        input  s_valid, s_addr, s_data, s_web,
        input  a_valid, a_addr, a_data, a_web,
        input  m_ready,
        output s_ready, a_hit, a_drop,
        output m_valid, m_addr, m_data, m_web,
        output count, full, empty
    );

    modport master (
        output s_valid, s_addr, s_data, s_web,
        output a_valid, a_addr, a_data, a_web,
        output m_ready,
        input  s_ready, a_hit, a_drop,
        input  m_valid, m_addr, m_data, m_web,
        input  count, full, empty
    );
endinterface

// File: rtl/conv_acc_queue.sv
// Write-combining FIFO of partial sums: stores allocate/overwrite, accumulates add lane-wise into resident entries.
// Head visible on m_* combinationally; store misses stall only when full, accumulates are never stalled (dropped instead).
module conv_acc_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 17,
    parameter int LANES  = 2,
    parameter int LANE_W = 16,
    parameter int SAT_EN = 1
) (
    input  logic clk,
    input  logic rst,
    conv_acc_queue_if.slave q_if
);
    localparam int DATA_W = LANES * LANE_W;
    localparam int WEB_W  = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [WEB_W-1:0]  r_web  [DEPTH];
    logic [PTR_W-1:0]  r_front;
    logic [PTR_W-1:0]  r_rear;
    logic [CNT_W-1:0]  r_count;
    logic              r_a_drop;

    logic              w_full;
    logic              w_pop;
    logic              w_s_hit;
    logic              w_s_upd;
    logic              w_s_enq;
    logic [PTR_W-1:0]  w_s_idx;
    logic              w_a_match;
    logic              w_a_hit;
    logic [PTR_W-1:0]  w_a_idx;
    logic [DATA_W-1:0] w_acc_data;

    // Sign-extended add; differing top two bits of the sum mean signed overflow.
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] x,
                                                   input logic [LANE_W-1:0] y);
        logic [LANE_W:0] sum;
        sum = {x[LANE_W-1], x} + {y[LANE_W-1], y};
        if (SAT_EN != 0 && sum[LANE_W] != sum[LANE_W-1]) begin
            return sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end
        return sum[LANE_W-1:0];
    endfunction

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = r_vld[r_front] & q_if.m_ready;

    // The departing head is excluded so a same-address store re-allocates behind it.
    always_comb begin
        w_s_hit   = 1'b0;
        w_s_idx   = '0;
        w_a_match = 1'b0;
        w_a_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && !(w_pop && PTR_W'(i) == r_front)) begin
                if (r_addr[i] == q_if.s_addr) begin
                    w_s_hit = 1'b1;
                    w_s_idx = PTR_W'(i);
                end
                if (r_addr[i] == q_if.a_addr) begin
                    w_a_match = 1'b1;
                    w_a_idx   = PTR_W'(i);
                end
            end
        end
    end

    assign w_s_upd = q_if.s_valid & w_s_hit;
    assign w_s_enq = q_if.s_valid & ~w_s_hit & ~w_full;
    assign w_a_hit = q_if.a_valid & w_a_match & ~(w_s_upd && w_s_idx == w_a_idx);

    always_comb begin
        w_acc_data = '0;
        for (int l = 0; l < LANES; l++) begin
            w_acc_data[l*LANE_W +: LANE_W] = lane_add(r_data[w_a_idx][l*LANE_W +: LANE_W],
                                                      q_if.a_data[l*LANE_W +: LANE_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_front  <= '0;
            r_rear   <= '0;
            r_count  <= '0;
            r_a_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_web[i]  <= '1;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && PTR_W'(i) == r_front) begin
                    r_vld[i] <= 1'b0;
                end
                if (w_s_enq && PTR_W'(i) == r_rear) begin
                    r_vld[i]  <= 1'b1;
                    r_addr[i] <= q_if.s_addr;
                    r_data[i] <= q_if.s_data;
                    r_web[i]  <= q_if.s_web;
                end else if (w_s_upd && PTR_W'(i) == w_s_idx) begin
                    r_data[i] <= q_if.s_data;
                    r_web[i]  <= r_web[i] & q_if.s_web;
                end else if (w_a_hit && PTR_W'(i) == w_a_idx) begin
                    r_data[i] <= w_acc_data;
                    r_web[i]  <= r_web[i] & q_if.a_web;
                end
            end
            if (w_pop) begin
                r_front <= r_front + PTR_W'(1);
            end
            if (w_s_enq) begin
                r_rear <= r_rear + PTR_W'(1);
            end
            r_count  <= r_count + CNT_W'(w_s_enq) - CNT_W'(w_pop);
            r_a_drop <= q_if.a_valid & ~w_a_hit;
        end
    end

    assign q_if.s_ready = w_s_hit | ~w_full;
    assign q_if.a_hit   = w_a_hit;
    assign q_if.a_drop  = r_a_drop;
    assign q_if.m_valid = r_vld[r_front];
    assign q_if.m_addr  = r_addr[r_front];
    assign q_if.m_data  = r_data[r_front];
    assign q_if.m_web   = r_web[r_front];
    assign q_if.count   = r_count;
    assign q_if.full    = w_full;
    assign q_if.empty   = (r_count == '0);
endmodule
